muldiv_ctrl: RTL and testbench

- Sequencing controller for the shared iterative divider and multiplier in the EX stage of the pipelined MIPS-Lite CPU.
- Owns the HI/LO architectural registers and accepts MULTU/DIVU/MFHI/MFLO/MTHI/MTLO from EX.
- Launches the selected unit with a one-cycle start pulse, counts its fixed latency and captures the 64-bit result into HI/LO.
- Stalls the pipeline while a result is outstanding.

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_lat_counter.sv | 28 ++
 rtl/muldiv_ctrl.sv | 172 +++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op codes,
// FSM encoding, latency-counter width and the divide-by-zero LO value.
package muldiv_pkg;

  localparam int CNT_W = 6;

  localparam logic [2:0] OP_MULTU = 3'd0;
  localparam logic [2:0] OP_DIVU  = 3'd1;
  localparam logic [2:0] OP_MFHI  = 3'd2;
  localparam logic [2:0] OP_MFLO  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DIV_RUN = 2'd2
  } state_t;

  // The counter is loaded with LAT-1 so that it reads zero in the cycle whose
  // closing edge captures the result.
  function automatic logic [CNT_W-1:0] lat_load(input int lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/muldiv_lat_counter.sv
// Loadable down-counter with zero flag, shared by both run states to time
// the fixed latency of the external divider and multiplier.
module muldiv_lat_counter
  import muldiv_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO owner for the EX stage: launches the shared multiplier or divider,
// waits out its fixed latency, captures the 64-bit result and stalls EX.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int DIV_LAT = 34,
  parameter int MUL_LAT = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  output logic        stall,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        div_start,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [63:0] div_result,
  output logic        mul_start,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_result,
  output logic        busy,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] DIV_LOAD = lat_load(DIV_LAT);
  localparam logic [CNT_W-1:0] MUL_LOAD = lat_load(MUL_LAT);

  state_t           state, state_next;
  logic             accept;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;
  logic             launch_mul, launch_div, div_by_zero;
  logic             write_hi, write_lo, capture;

  assign busy   = (state != IDLE);
  assign stall  = op_valid && busy && !flush;
  assign accept = op_valid && !flush && (state == IDLE);

  muldiv_lat_counter u_lat_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    launch_mul   = 1'b0;
    launch_div   = 1'b0;
    div_by_zero  = 1'b0;
    write_hi     = 1'b0;
    write_lo     = 1'b0;
    capture      = 1'b0;
    rd_valid     = 1'b0;
    rd_data      = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          case (op_code)
            OP_MULTU: begin
              launch_mul   = 1'b1;
              cnt_load     = 1'b1;
              cnt_load_val = MUL_LOAD;
              state_next   = MUL_RUN;
            end
            OP_DIVU: begin
              if (op_b != '0) begin
                launch_div   = 1'b1;
                cnt_load     = 1'b1;
                cnt_load_val = DIV_LOAD;
                state_next   = DIV_RUN;
              end else begin
                div_by_zero = 1'b1;
              end
            end
            OP_MFHI: begin
              rd_valid = 1'b1;
              rd_data  = hi;
            end
            OP_MFLO: begin
              rd_valid = 1'b1;
              rd_data  = lo;
            end
            OP_MTHI: write_hi = 1'b1;
            OP_MTLO: write_lo = 1'b1;
            default: ;
          endcase
        end
      end
      MUL_RUN, DIV_RUN: begin
        // A flush in the completion cycle still discards the result.
        if (flush) begin
          state_next = IDLE;
        end else if (cnt_zero) begin
          capture    = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (capture) begin
      if (state == DIV_RUN) begin
        hi <= div_result[63:32];
        lo <= div_result[31:0];
      end else begin
        hi <= mul_result[63:32];
        lo <= mul_result[31:0];
      end
    end else if (div_by_zero) begin
      hi <= op_a;
      lo <= DIV0_LO;
    end else begin
      if (write_hi) hi <= op_a;
      if (write_lo) lo <= op_a;
    end
  end

  // Start pulses and operands are registered; operands hold until the next launch.
  always_ff @(posedge clk) begin
    if (reset) begin
      mul_start <= 1'b0;
      div_start <= 1'b0;
      div_zero  <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      div_a     <= '0;
      div_b     <= '0;
    end else begin
      mul_start <= launch_mul;
      div_start <= launch_div;
      div_zero  <= div_by_zero;
      if (launch_mul) begin
        mul_a <= op_a;
        mul_b <= op_b;
      end
      if (launch_div) begin
        div_a <= op_a;
        div_b <= op_b;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a cycle-numbered HI/LO model.
module tb_muldiv_ctrl;

  localparam int DIV_LAT = 34;
  localparam int MUL_LAT = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic [2:0]  op_code = 3'd0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        flush = 1'b0;
  logic [63:0] div_result = '0;
  logic [63:0] mul_result = '0;
  logic        stall, rd_valid, div_start, mul_start, busy, div_zero;
  logic [31:0] rd_data, div_a, div_b, mul_a, mul_b, hi, lo;

  muldiv_ctrl #(.DIV_LAT(DIV_LAT), .MUL_LAT(MUL_LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .op_valid   (op_valid),
    .op_code    (op_code),
    .op_a       (op_a),
    .op_b       (op_b),
    .flush      (flush),
    .stall      (stall),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .div_start  (div_start),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_result (div_result),
    .mul_start  (mul_start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result),
    .busy       (busy),
    .div_zero   (div_zero),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Model: architectural HI/LO plus at most one outstanding operation that
  // completes in absolute cycle m_done (accept cycle + latency).
  logic [31:0] m_hi = '0, m_lo = '0, m_a = '0, m_b = '0;
  logic [63:0] m_res = '0;
  bit          m_busy = 0, m_kdiv = 0, m_mst = 0, m_dst = 0, m_dz = 0;
  int          cyc = 0;
  int          m_done = -1;

  always @(negedge clk) begin
    bit done_now, exp_rdv;
    done_now = (cyc == m_done);
    // Units present the true result only in the completion cycle, noise otherwise.
    mul_result = (done_now && !m_kdiv) ? m_res : {$urandom, $urandom};
    div_result = (done_now && m_kdiv) ? m_res : {$urandom, $urandom};
    if (!reset) begin
      exp_rdv = op_valid && !flush && !m_busy && (op_code == 3'd2 || op_code == 3'd3);
      chk("stall", stall, op_valid && m_busy && !flush);
      chk("rd_valid", rd_valid, exp_rdv);
      if (exp_rdv) chk("rd_data", rd_data, (op_code == 3'd2) ? m_hi : m_lo);
      chk("busy", busy, m_busy);
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      chk("mul_start", mul_start, m_mst);
      chk("div_start", div_start, m_dst);
      chk("div_zero", div_zero, m_dz);
      if (m_busy && m_kdiv) begin
        chk("div_a", div_a, m_a);
        chk("div_b", div_b, m_b);
      end else if (m_busy) begin
        chk("mul_a", mul_a, m_a);
        chk("mul_b", mul_b, m_b);
      end
    end
    m_mst = 0;
    m_dst = 0;
    m_dz  = 0;
    if (reset) begin
      m_hi = '0;
      m_lo = '0;
      m_busy = 0;
    end else if (m_busy) begin
      if (flush) m_busy = 0;
      else if (done_now) begin
        m_hi = m_res[63:32];
        m_lo = m_res[31:0];
        m_busy = 0;
      end
    end else if (op_valid && !flush) begin
      case (op_code)
        3'd0: begin
          m_busy = 1; m_kdiv = 0; m_mst = 1; m_a = op_a; m_b = op_b;
          m_res = {32'd0, op_a} * {32'd0, op_b};
          m_done = cyc + MUL_LAT;
        end
        3'd1: begin
          if (op_b == 0) begin
            m_hi = op_a; m_lo = 32'hFFFF_FFFF; m_dz = 1;
          end else begin
            m_busy = 1; m_kdiv = 1; m_dst = 1; m_a = op_a; m_b = op_b;
            m_res = {op_a % op_b, op_a / op_b};
            m_done = cyc + DIV_LAT;
          end
        end
        3'd4: m_hi = op_a;
        3'd5: m_lo = op_a;
        default: ;
      endcase
    end
    cyc++;
  end

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic put(input bit v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    op_valid = v;
    op_code  = op;
    op_a     = a;
    op_b     = b;
  endtask

  initial begin
    int n_ds, n_ms, n_busy, n_stall;
    bit ds_first, got;
    logic [31:0] got_data;

    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_starts", {mul_start, div_start, div_zero}, 3'b000);

    // DIVU 100/7
    nxt();
    put(1, 3'd1, 32'd100, 32'd7);
    nxt();
    put(0, 3'd0, 0, 0);
    ds_first = div_start;
    n_ds = 0; n_busy = 0;
    for (int k = 1; k <= DIV_LAT; k++) begin
      n_ds += int'(div_start);
      n_busy += int'(busy);
      nxt();
    end
    chk("divu_start_T1", ds_first, 1'b1);
    chk("divu_start_count", n_ds, 1);
    chk("divu_busy_cycles", n_busy, DIV_LAT);
    chk("divu_hi", hi, 32'd2);
    chk("divu_lo", lo, 32'd14);
    chk("divu_idle", busy, 1'b0);

    // MULTU FFFFFFFF * 2
    put(1, 3'd0, 32'hFFFF_FFFF, 32'd2);
    nxt();
    put(0, 3'd0, 0, 0);
    n_ms = 0; n_ds = 0;
    for (int k = 1; k <= MUL_LAT; k++) begin
      n_ms += int'(mul_start);
      n_ds += int'(div_start);
      nxt();
    end
    chk("multu_start_count", n_ms, 1);
    chk("multu_no_div_start", n_ds, 0);
    chk("multu_hi", hi, 32'd1);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    // DIVU 100/7 then dependent MFLO held
    put(1, 3'd1, 32'd100, 32'd7);
    nxt();
    put(1, 3'd3, 0, 0);
    n_stall = 0; got = 0; got_data = '0;
    for (int k = 0; k < 100 && !got; k++) begin
      #1;
      if (rd_valid) begin
        got = 1;
        got_data = rd_data;
      end else begin
        n_stall += int'(stall);
        nxt();
      end
    end
    chk("mflo_answered", got, 1'b1);
    chk("mflo_stall_cycles", n_stall, DIV_LAT);
    chk("mflo_data", got_data, 32'd14);
    chk("mflo_no_stall", stall, 1'b0);
    nxt();
    put(0, 3'd0, 0, 0);

    // DIVU 5/0
    nxt();
    put(1, 3'd1, 32'd5, 32'd0);
    nxt();
    put(0, 3'd0, 0, 0);
    chk("div0_pulse", div_zero, 1'b1);
    chk("div0_no_start", div_start, 1'b0);
    chk("div0_busy", busy, 1'b0);
    chk("div0_hi", hi, 32'd5);
    chk("div0_lo", lo, 32'hFFFF_FFFF);
    nxt();
    chk("div0_pulse_end", div_zero, 1'b0);

    // MTHI, then DIVU 9/4 flushed in run cycle 10
    put(1, 3'd4, 32'hDEAD_BEEF, 0);
    nxt();
    put(1, 3'd1, 32'd9, 32'd4);
    nxt();
    put(0, 3'd0, 0, 0);
    repeat (9) nxt();
    flush = 1'b1;
    nxt();
    flush = 1'b0;
    chk("flush_idle", busy, 1'b0);
    chk("flush_hi", hi, 32'hDEAD_BEEF);
    repeat (30) nxt();
    chk("flush_discard_hi", hi, 32'hDEAD_BEEF);
    put(1, 3'd2, 0, 0);
    #1;
    chk("flush_mfhi_valid", rd_valid, 1'b1);
    chk("flush_mfhi_data", rd_data, 32'hDEAD_BEEF);
    nxt();
    put(0, 3'd0, 0, 0);

    // Reset in run cycle 20 of a MULTU
    put(1, 3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    nxt();
    put(0, 3'd0, 0, 0);
    repeat (19) nxt();
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    #1;
    chk("rst_run_busy", busy, 1'b0);
    chk("rst_run_hilo", {hi, lo}, 64'd0);
    chk("rst_run_pulses", {mul_start, div_start, div_zero, stall, rd_valid}, 5'd0);
    chk("rst_run_operands", {mul_a, mul_b}, 64'd0);
    repeat (MUL_LAT) nxt();
    chk("rst_run_no_capture", {hi, lo}, 64'd0);

    // Randomized traffic
    for (int k = 0; k < 4000; k++) begin
      reset    = ($urandom_range(0, 399) == 0);
      flush    = ($urandom_range(0, 49) == 0);
      op_valid = $urandom_range(0, 1) == 1;
      op_code  = 3'($urandom_range(0, 7));
      op_a     = $urandom;
      if ($urandom_range(0, 5) == 0) op_b = '0;
      else if ($urandom_range(0, 1) == 1) op_b = $urandom_range(1, 20);
      else op_b = $urandom;
      nxt();
    end
    reset = 1'b0;
    flush = 1'b0;
    put(0, 3'd0, 0, 0);
    repeat (2) nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
